// File: rtl/inst_aligner.sv
// inst_aligner: fetch-to-decode realignment buffer for RV32IMC.
// Accepts 32-bit fetch words, queues them as 16-bit halfwords and hands
// decode one whole instruction (16-bit compressed or 32-bit, possibly
// straddling two fetch words) per cycle, together with its PC.
//
// Handshakes (both ports): a transfer happens on a rising edge where the
// producer's valid and the consumer's ready are both high. The fetch side
// additionally drops the transfer when i_flush is high. Neither ready depends
// combinationally on the other side's valid: o_fetch_ready depends only on
// buffered occupancy and i_flush. o_inst_valid depends only on buffered state
// and i_flush, never on the fetch inputs.
module inst_aligner #(
  parameter int HW_DEPTH = 8  // halfword capacity; even and at least 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_flush,
  input  logic        i_fetch_valid,
  input  logic [31:0] i_fetch_pc,
  input  logic [31:0] i_fetch_word,
  output logic        o_fetch_ready,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  output logic        o_inst_compressed,
  input  logic        i_inst_ready
);

  localparam int PW = $clog2(HW_DEPTH);
  localparam int CW = $clog2(HW_DEPTH + 1);
  // Highest occupancy that still leaves room for a full two-halfword push.
  localparam logic [CW-1:0] READY_MAX = CW'(HW_DEPTH - 2);

  // Circular pointer advance; HW_DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int n);
    int s;
    s = int'(p) + n;
    if (s >= HW_DEPTH) s = s - HW_DEPTH;
    return s[PW-1:0];
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [15:0]   mem_q [HW_DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   head_pc_q, head_pc_d;

  // ---------------------------------------------------------------------
  // Head decode (purely from registered state)
  // ---------------------------------------------------------------------
  logic [PW-1:0] head_p1;
  logic [PW-1:0] tail_p1;
  logic [15:0]   h0;
  logic [15:0]   h1;
  logic          head_is_comp;
  logic          not_empty;
  logic          avail;

  assign head_p1      = ptr_add(head_q, 1);
  assign tail_p1      = ptr_add(tail_q, 1);
  assign h0           = mem_q[head_q];
  assign h1           = mem_q[head_p1];
  assign head_is_comp = (h0[1:0] != 2'b11);
  assign not_empty    = (count_q != '0);
  // A 32-bit instruction needs both halves present; anything whose low bits
  // are 11 is treated as 32-bit (longer encodings are decode's problem).
  assign avail        = not_empty && (head_is_comp || (count_q >= CW'(2)));

  // ---------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------
  logic          accept;
  logic          pop;
  logic [CW-1:0] push_cnt;
  logic [CW-1:0] pop_cnt;
  logic [CW-1:0] count_after_pop;

  // Backpressure looks at occupancy before any same-cycle pop, so it has no
  // path from i_inst_ready.
  assign o_fetch_ready = (count_q <= READY_MAX) && !i_flush;
  assign o_inst_valid  = avail && !i_flush;

  assign accept = i_fetch_valid && o_fetch_ready;
  assign pop    = o_inst_valid && i_inst_ready;

  // Halfwords added / removed on this edge.
  always_comb begin
    push_cnt = '0;
    pop_cnt  = '0;
    if (accept) push_cnt = i_fetch_pc[1] ? CW'(1) : CW'(2);
    if (pop)    pop_cnt  = head_is_comp ? CW'(1) : CW'(2);
  end

  assign count_after_pop = count_q - pop_cnt;

  // Output formatting; an empty buffer shows all-zero instruction fields.
  assign o_inst            = !not_empty   ? 32'h0 :
                             head_is_comp ? {16'h0, h0} : {h1, h0};
  assign o_inst_compressed = not_empty && head_is_comp;
  assign o_inst_pc         = head_pc_q;

  // Bit 0 of the fetch PC carries no information for halfword-aligned code.
  logic unused_fetch_pc0;
  assign unused_fetch_pc0 = i_fetch_pc[0];

  // ---------------------------------------------------------------------
  // Next-state computation
  // ---------------------------------------------------------------------
  // Pointer, occupancy and head PC next-state, with flush overriding.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    head_pc_d = head_pc_q;
    if (i_flush) begin
      // Buffered halfwords are discarded; head_pc is left stale and is
      // reloaded by the next accepted word because count will be zero.
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop) begin
        head_d    = ptr_add(head_q, head_is_comp ? 1 : 2);
        head_pc_d = head_pc_q + (head_is_comp ? 32'd2 : 32'd4);
      end
      if (accept) begin
        tail_d = ptr_add(tail_q, i_fetch_pc[1] ? 1 : 2);
        // A word landing in an (about to be) empty buffer defines the PC
        // of the new head; otherwise the stream is assumed sequential.
        if (count_after_pop == '0) head_pc_d = {i_fetch_pc[31:1], 1'b0};
      end
      count_d = count_after_pop + push_cnt;
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  // Control state: pointers, occupancy, head PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      head_pc_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      head_pc_q <= head_pc_d;
    end
  end

  // Halfword storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      if (i_fetch_pc[1]) begin
        mem_q[tail_q] <= i_fetch_word[31:16];
      end else begin
        mem_q[tail_q]  <= i_fetch_word[15:0];
        mem_q[tail_p1] <= i_fetch_word[31:16];
      end
    end
  end

endmodule

// File: tb/tb_inst_aligner.sv
// Testbench for inst_aligner: directed scenarios plus a randomized run,
// all checked against a halfword-queue reference model.
module tb_inst_aligner;

  localparam int HW_DEPTH = 8;

  // ---------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------
  logic        clk;
  logic        rst;
  logic        i_flush;
  logic        i_fetch_valid;
  logic [31:0] i_fetch_pc;
  logic [31:0] i_fetch_word;
  logic        o_fetch_ready;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        o_inst_compressed;
  logic        i_inst_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  inst_aligner #(.HW_DEPTH(HW_DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_flush           (i_flush),
    .i_fetch_valid     (i_fetch_valid),
    .i_fetch_pc        (i_fetch_pc),
    .i_fetch_word      (i_fetch_word),
    .o_fetch_ready     (o_fetch_ready),
    .o_inst_valid      (o_inst_valid),
    .o_inst            (o_inst),
    .o_inst_pc         (o_inst_pc),
    .o_inst_compressed (o_inst_compressed),
    .i_inst_ready      (i_inst_ready)
  );

  // ---------------------------------------------------------------------
  // Scoreboard: reference model is a queue of buffered halfwords, each
  // tagged with its own byte address.
  // ---------------------------------------------------------------------
  logic [15:0] exp_q[$];
  logic [31:0] pc_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Driver: one clock cycle. Inputs are applied after the falling edge,
  // outputs are compared against the model, then the model takes the
  // effect of the coming rising edge.
  // ---------------------------------------------------------------------
  task automatic cycle(input logic fv, input logic [31:0] fpc, input logic [31:0] fw,
                       input logic ir, input logic fl, input logic r, output logic acc);
    logic        e_ready, e_valid, e_comp;
    logic [31:0] e_inst, e_pc, base;
    int          n;
    @(negedge clk);
    rst           = r;
    i_flush       = fl;
    i_fetch_valid = fv;
    i_fetch_pc    = fpc;
    i_fetch_word  = fw;
    i_inst_ready  = ir;
    #1;
    n       = exp_q.size();
    e_ready = (n <= HW_DEPTH - 2) && !fl;
    e_comp  = (n >= 1) && (exp_q[0][1:0] != 2'b11);
    e_valid = !fl && (n >= 1) && (e_comp || n >= 2);
    e_inst  = 32'h0;
    e_pc    = 32'h0;
    if (n >= 1) begin
      e_pc   = pc_q[0];
      e_inst = e_comp ? {16'h0, exp_q[0]} : ((n >= 2) ? {exp_q[1], exp_q[0]} : 32'h0);
    end
    check("fetch_ready", {31'h0, o_fetch_ready}, {31'h0, e_ready});
    check("inst_valid", {31'h0, o_inst_valid}, {31'h0, e_valid});
    if (e_valid) begin
      check("inst", o_inst, e_inst);
      check("inst_pc", o_inst_pc, e_pc);
      check("inst_compressed", {31'h0, o_inst_compressed}, {31'h0, e_comp});
    end
    acc = fv && e_ready && !r;
    if (r || fl) begin
      exp_q.delete();
      pc_q.delete();
    end else begin
      if (e_valid && ir) begin
        repeat (e_comp ? 1 : 2) begin
          void'(exp_q.pop_front());
          void'(pc_q.pop_front());
        end
      end
      if (acc) begin
        base = {fpc[31:2], 2'b00};
        if (!fpc[1]) begin
          exp_q.push_back(fw[15:0]);
          pc_q.push_back(base);
        end
        exp_q.push_back(fw[31:16]);
        pc_q.push_back(base + 32'd2);
      end
    end
  endtask

  task automatic idle(input logic ir);
    logic acc;
    cycle(1'b0, 32'h0, 32'h0, ir, 1'b0, 1'b0, acc);
  endtask

  task automatic push_word(input logic [31:0] pc, input logic [31:0] w, input logic ir);
    logic acc;
    cycle(1'b1, pc, w, ir, 1'b0, 1'b0, acc);
  endtask

  task automatic expect_inst(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                             input logic comp);
    check({tag, "_valid"}, {31'h0, o_inst_valid}, 32'h1);
    check({tag, "_inst"}, o_inst, inst);
    check({tag, "_pc"}, o_inst_pc, pc);
    check({tag, "_comp"}, {31'h0, o_inst_compressed}, {31'h0, comp});
  endtask

  task automatic expect_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'h0, o_inst_valid}, 32'h0);
    check({tag, "_ready"}, {31'h0, o_fetch_ready}, 32'h1);
    check({tag, "_inst"}, o_inst, 32'h0);
    check({tag, "_pc"}, o_inst_pc, 32'h0);
    check({tag, "_comp"}, {31'h0, o_inst_compressed}, 32'h0);
  endtask

  function automatic logic [15:0] rand_hw();
    logic [15:0] h;
    h = 16'($urandom());
    if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
    return h;
  endfunction

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    logic        acc;
    logic [31:0] gen_pc;
    int          k;

    rst = 1'b1; i_flush = 1'b0; i_fetch_valid = 1'b0;
    i_fetch_pc = 32'h0; i_fetch_word = 32'h0; i_inst_ready = 1'b0;
    repeat (3) @(posedge clk);

    // 32-bit stream, starting in the first cycle after reset
    push_word(32'h0, 32'h00150513, 1'b1);
    expect_reset_outputs("after_reset");
    push_word(32'h4, 32'h00A00593, 1'b1);
    expect_inst("s32_a", 32'h00150513, 32'h0, 1'b0);
    idle(1'b1);
    expect_inst("s32_b", 32'h00A00593, 32'h4, 1'b0);
    idle(1'b1);
    check("s32_empty", {31'h0, o_inst_valid}, 32'h0);

    // Compressed pair
    push_word(32'h0, 32'h45854501, 1'b1);
    idle(1'b1);
    expect_inst("cpair_a", 32'h00004501, 32'h0, 1'b1);
    idle(1'b1);
    expect_inst("cpair_b", 32'h00004585, 32'h2, 1'b1);
    idle(1'b1);

    // Straddle across two fetch words
    push_word(32'h0, 32'h05134501, 1'b1);
    idle(1'b1);
    expect_inst("strad_a", 32'h00004501, 32'h0, 1'b1);
    idle(1'b1);
    check("strad_wait", {31'h0, o_inst_valid}, 32'h0);
    push_word(32'h4, 32'h45010015, 1'b1);
    check("strad_wait2", {31'h0, o_inst_valid}, 32'h0);
    idle(1'b1);
    expect_inst("strad_b", 32'h00150513, 32'h2, 1'b0);
    idle(1'b1);
    expect_inst("strad_c", 32'h00004501, 32'h6, 1'b1);
    idle(1'b1);

    // Odd start: low halfword skipped
    push_word(32'h102, 32'h45010000, 1'b1);
    idle(1'b1);
    expect_inst("odd", 32'h00004501, 32'h102, 1'b1);
    idle(1'b1);
    check("odd_single", {31'h0, o_inst_valid}, 32'h0);

    // Backpressure: decode stalled, fetch streams 32-bit words
    k = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 32'h200 + 32'(4 * k), 32'h00100013 + (32'(k) << 20), 1'b0, 1'b0, 1'b0, acc);
      check("bp_ready", {31'h0, o_fetch_ready}, (i < 4) ? 32'h1 : 32'h0);
      if (acc) k++;
    end
    check("bp_accepted", 32'(k), 32'd4);
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      expect_inst("bp_drain", 32'h00100013 + (32'(i) << 20), 32'h200 + 32'(4 * i), 1'b0);
      check("bp_ready_drain", {31'h0, o_fetch_ready}, (i == 0) ? 32'h0 : 32'h1);
    end
    idle(1'b1);
    check("bp_empty", {31'h0, o_inst_valid}, 32'h0);

    // Flush with a half-buffered 32-bit instruction
    push_word(32'h0, 32'h05134501, 1'b1);
    idle(1'b1);
    expect_inst("fl_a", 32'h00004501, 32'h0, 1'b1);
    cycle(1'b1, 32'h8, 32'h11111111, 1'b1, 1'b1, 1'b0, acc);
    check("fl_ready", {31'h0, o_fetch_ready}, 32'h0);
    check("fl_valid", {31'h0, o_inst_valid}, 32'h0);
    push_word(32'h40, 32'h00A00593, 1'b1);
    check("fl_empty", {31'h0, o_inst_valid}, 32'h0);
    idle(1'b1);
    expect_inst("fl_b", 32'h00A00593, 32'h40, 1'b0);
    idle(1'b1);
    check("fl_only", {31'h0, o_inst_valid}, 32'h0);

    // Same with reset in place of flush
    push_word(32'h0, 32'h05134501, 1'b1);
    idle(1'b1);
    expect_inst("rst_a", 32'h00004501, 32'h0, 1'b1);
    cycle(1'b1, 32'h4, 32'h45010015, 1'b0, 1'b0, 1'b1, acc);
    idle(1'b0);
    expect_reset_outputs("mid_reset");

    // Randomized run: sequential fetch between redirects, varying decode rate
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, acc);
    gen_pc = $urandom();
    for (int i = 0; i < 4000; i++) begin
      logic fv, ir, fl, r;
      fv = ($urandom_range(0, 3) != 0);
      ir = ((i / 400) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 79) == 0);
      r  = ($urandom_range(0, 399) == 0);
      cycle(fv, gen_pc, {rand_hw(), rand_hw()}, ir, fl, r, acc);
      if (fl || r) gen_pc = $urandom();
      else if (acc) gen_pc = {gen_pc[31:2], 2'b00} + 32'd4;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_aligner.md
# inst_aligner

Fetch-to-decode realignment buffer for the RV32IMC pipeline. It accepts 32-bit aligned fetch words and stores them as a parametrised queue of 16-bit halfwords. It emits one whole instruction per cycle, either a 16-bit compressed instruction or a 32-bit instruction that may straddle two fetch words, together with its PC and a compressed flag. It sits between the fetch stage and the control/decode stage and replaces direct word-at-a-time instruction delivery.

## Interface
- HW_DEPTH, 8: halfword queue capacity; even, ≥4.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous and active-high; dominates every other input.
- i_flush  in  1  redirect; discards all buffered halfwords this cycle.
- i_fetch_valid  in  1  fetch word valid.
- i_fetch_pc  in  32  byte address of the halfword that starts this fetch word. Bit 1 set means the low halfword is skipped; bit 0 is ignored.
- i_fetch_word  in  32  fetch data, little-endian; halfword at `pc & ~3` is in [15:0].
- o_fetch_ready  out  1  word accepted on an edge where valid && ready && !i_flush.
- o_inst_valid  out  1  o_inst holds a complete instruction.
- o_inst  out  32  instruction; compressed instructions are zero-extended in [15:0].
- o_inst_pc  out  32  byte address of o_inst.
- o_inst_compressed  out  1  o_inst[1:0] != 2'b11.
- i_inst_ready  in  1  decode consumes the instruction on an edge where valid && ready.

## Operation
- Storage: circular halfword array HW_DEPTH×16, with head/tail pointers (modulo HW_DEPTH) and a count of width $clog2(HW_DEPTH+1). It also holds a head_pc register.
- Push:
  - On an accepted fetch word, append halfword [15:0] then [31:16].
  - If i_fetch_pc[1]=1, append only [31:16].
- head_pc load: if count==0 after any pop this cycle, head_pc loads {i_fetch_pc[31:1],1'b0} on push.
- Pop and PC advance: on handshake, head advances by 1 (compressed) or 2 (32-bit), and head_pc increments by 2 or 4. The count update is push − pop, including when both happen in the same cycle.
- Instruction availability:
  - Head halfword h0 is compressed if h0[1:0]!=2'b11. It needs count≥1.
  - Otherwise the instruction is 32-bit and needs count≥2, with o_inst={h1,h0}.
  - A 32-bit instruction with only its low half buffered waits. o_inst_valid=0 until the upper half arrives.
- Output timing: o_inst_valid = available && !i_flush. o_inst, o_inst_pc and o_inst_compressed are driven from registered state, with no combinational path from fetch inputs. When o_inst_valid=0 their values are don't-care.
- Fetch backpressure: o_fetch_ready = (count ≤ HW_DEPTH−2) && !i_flush. It is computed from count before the same-cycle pop, so there is no path from i_inst_ready.
- Flush:
  - count, head and tail are cleared to 0.
  - A fetch word presented in the flush cycle is dropped.
  - A pop in the flush cycle is ignored.
  - The next accepted word reloads head_pc.
- No instruction-length checks beyond bits [1:0]. 48-bit or larger encodings are treated as 32-bit; illegal detection is downstream.
- Sequential fetch is required between flushes. PCs of later words are not checked.

## Timing
- Reset values: count=0, head=tail=0, head_pc=0, o_inst_valid=0, o_fetch_ready=1, o_inst=0, o_inst_pc=0, o_inst_compressed=0.
- The first cycle after rst deassert accepts fetch.
- Latency: a word accepted at edge N makes its first complete instruction valid in the cycle after N.
- Throughput: at most one instruction per cycle.
  - A pure 32-bit stream sustains 1 instr/cycle.
  - A compressed stream fills the queue; ready then stalls fetch at 2 halfwords per word.
- Full: count ≥ HW_DEPTH−1 gives ready=0. A simultaneous pop does not raise ready in the same cycle.
- Empty: count=0 gives o_inst_valid=0. There is no bypass of fetch to output.
- Pointers wrap from HW_DEPTH−1 to 0. A 32-bit instruction whose halves span the wrap point is assembled correctly.
- rst asserted mid-operation, including mid-straddle, returns to the reset values on the next edge. Pending halfwords are lost.

## Test plan
- 32-bit stream: words 0x00150513 @0x0, 0x00A00593 @0x4, i_inst_ready=1 → o_inst 0x00150513 pc 0x0, then 0x00A00593 pc 0x4, one per cycle, compressed=0.
- Compressed pair: word 0x45854501 @0x0 → 0x00004501 pc 0x0 then 0x00004585 pc 0x2, compressed=1, in consecutive cycles.
- Straddle: word 0x05134501 @0x0, then 0x45010015 @0x4:
  - 0x00004501 pc 0x0;
  - valid=0 until the second word is accepted;
  - 0x00150513 pc 0x2;
  - 0x00004501 pc 0x6.
- Odd start: word 0x45010000 @0x102 → single output 0x00004501 pc 0x102; the low halfword is never emitted.
- Backpressure: HW_DEPTH=8, i_inst_ready=0, continuous valid 32-bit words → exactly 4 words accepted, then ready=0. Release ready → the 4 instructions drain in order, and ready returns once count ≤6.
- Flush and reset:
  - Word 0x05134501 @0x0 buffered with the 32-bit upper half missing. Pulse i_flush, then word 0x00A00593 @0x40 → output 0x00A00593 pc 0x40 only.
  - Repeat with rst instead of i_flush → all outputs return to their reset values on the next edge.
